// File: rtl/ysyx_24090018_wbu_pkg.sv
// Shared constants for the write-back unit: zero word, fixed register indices, FSM encodings.
package ysyx_24090018_wbu_pkg;

   localparam int unsigned XLEN     = 32;
   localparam int unsigned CNT_W    = 32;
   localparam int unsigned ZERO_IDX = 0;
   localparam int unsigned A0_IDX   = 10;

   localparam logic [XLEN-1:0] ZERO_WORD = '0;

   // Write-back FSM encodings
   localparam logic [0:0] RUN  = 1'b0;
   localparam logic [0:0] HALT = 1'b1;

endpackage

// File: rtl/ysyx_24090018_wbu_regfile.sv
// Architectural register file: two combinational read ports, one synchronous write port,
// x0 hardwired to zero, plus a dedicated x10 tap for the halt return code.
module ysyx_24090018_wbu_regfile
   import ysyx_24090018_wbu_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned REG_ADDR_W = 5
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  we,
   input  logic [REG_ADDR_W-1:0] waddr,
   input  logic [DATA_WIDTH-1:0] wdata,
   input  logic [REG_ADDR_W-1:0] raddr1,
   input  logic [REG_ADDR_W-1:0] raddr2,
   output logic [DATA_WIDTH-1:0] rdata1,
   output logic [DATA_WIDTH-1:0] rdata2,
   output logic [DATA_WIDTH-1:0] a0
);

   localparam int unsigned NUM_REGS = 1 << REG_ADDR_W;

   // Only x1..xN-1 exist as storage; x0 is never stored
   logic [DATA_WIDTH-1:0] regs [1:NUM_REGS-1];

   // Synchronous clear of all registers, otherwise single-port write (caller never targets x0)
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned i = 1; i < NUM_REGS; i++) begin
            regs[i] <= DATA_WIDTH'(ZERO_WORD);
         end
      end else if (we && (waddr != REG_ADDR_W'(ZERO_IDX))) begin
         regs[waddr] <= wdata;
      end
   end

   // Combinational reads with x0 forced to zero
   always_comb begin
      rdata1 = DATA_WIDTH'(ZERO_WORD);
      rdata2 = DATA_WIDTH'(ZERO_WORD);
      if (raddr1 != REG_ADDR_W'(ZERO_IDX)) rdata1 = regs[raddr1];
      if (raddr2 != REG_ADDR_W'(ZERO_IDX)) rdata2 = regs[raddr2];
   end

   assign a0 = regs[REG_ADDR_W'(A0_IDX)];

endmodule

// File: rtl/ysyx_24090018_wbu.sv
// Write-back unit: retires EXU results into the register file, serves IDU reads with
// same-cycle bypass, counts retirements and stops the core on ebreak.
module ysyx_24090018_wbu
   import ysyx_24090018_wbu_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned REG_ADDR_W = 5
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  exu_valid_i,
   output logic                  exu_ready_o,
   input  logic [DATA_WIDTH-1:0] pc_i,
   input  logic [DATA_WIDTH-1:0] rf_wdata_i,
   input  logic [REG_ADDR_W-1:0] rd_i,
   input  logic                  rf_wen_i,
   input  logic                  ebreak_i,
   input  logic [REG_ADDR_W-1:0] rs1_i,
   input  logic [REG_ADDR_W-1:0] rs2_i,
   output logic [DATA_WIDTH-1:0] rs1_data_o,
   output logic [DATA_WIDTH-1:0] rs2_data_o,
   output logic                  commit_valid_o,
   output logic [DATA_WIDTH-1:0] commit_pc_o,
   output logic [CNT_W-1:0]      retire_cnt_o,
   output logic                  halt_o,
   output logic [DATA_WIDTH-1:0] a0_o
);

   logic [0:0]            state_q;
   logic [0:0]            state_d;
   logic                  accept;
   logic                  rf_we;
   logic [DATA_WIDTH-1:0] rf_rdata1;
   logic [DATA_WIDTH-1:0] rf_rdata2;
   logic                  commit_valid_q;
   logic [DATA_WIDTH-1:0] commit_pc_q;
   logic [CNT_W-1:0]      retire_cnt_q;

   // Handshake: ready only while running; reset masks any transfer
   assign exu_ready_o = (state_q == RUN);
   assign accept      = exu_valid_i & exu_ready_o & ~rst;

   // ebreak suppresses the register write even when rf_wen_i is set
   assign rf_we = accept & rf_wen_i & ~ebreak_i & (rd_i != REG_ADDR_W'(ZERO_IDX));

   ysyx_24090018_wbu_regfile #(
      .DATA_WIDTH (DATA_WIDTH),
      .REG_ADDR_W (REG_ADDR_W)
   ) u_regfile (
      .clk    (clk),
      .rst    (rst),
      .we     (rf_we),
      .waddr  (rd_i),
      .wdata  (rf_wdata_i),
      .raddr1 (rs1_i),
      .raddr2 (rs2_i),
      .rdata1 (rf_rdata1),
      .rdata2 (rf_rdata2),
      .a0     (a0_o)
   );

   // Read ports with bypass of the write landing at the coming edge (x0 excluded by rf_we)
   always_comb begin
      rs1_data_o = rf_rdata1;
      rs2_data_o = rf_rdata2;
      if (rf_we && (rd_i == rs1_i)) rs1_data_o = rf_wdata_i;
      if (rf_we && (rd_i == rs2_i)) rs2_data_o = rf_wdata_i;
   end

   // FSM state register
   always_ff @(posedge clk) begin
      if (rst) state_q <= RUN;
      else     state_q <= state_d;
   end

   // FSM next state: ebreak retirement is the only way into HALT, reset the only way out
   always_comb begin
      state_d = state_q;
      case (state_q)
         RUN:     if (accept && ebreak_i) state_d = HALT;
         HALT:    state_d = HALT;
         default: state_d = RUN;
      endcase
   end

   // Retire bookkeeping: one-cycle commit pulse, held commit PC, wrapping retire counter
   always_ff @(posedge clk) begin
      if (rst) begin
         commit_valid_q <= 1'b0;
         commit_pc_q    <= DATA_WIDTH'(ZERO_WORD);
         retire_cnt_q   <= '0;
      end else begin
         commit_valid_q <= accept;
         if (accept) begin
            commit_pc_q  <= pc_i;
            retire_cnt_q <= retire_cnt_q + CNT_W'(1);
         end
      end
   end

   assign commit_valid_o = commit_valid_q;
   assign commit_pc_o    = commit_pc_q;
   assign retire_cnt_o   = retire_cnt_q;
   assign halt_o         = (state_q == HALT);

endmodule

// File: tb/tb_ysyx_24090018_wbu.sv
// Bench for the write-back unit: a behavioural register-file/retire model checked every
// cycle, plus directed vectors with hand-computed expectations.
module tb_ysyx_24090018_wbu;

   logic        clk;
   logic        rst;
   logic        exu_valid_i;
   logic        exu_ready_o;
   logic [31:0] pc_i;
   logic [31:0] rf_wdata_i;
   logic [4:0]  rd_i;
   logic        rf_wen_i;
   logic        ebreak_i;
   logic [4:0]  rs1_i;
   logic [4:0]  rs2_i;
   logic [31:0] rs1_data_o;
   logic [31:0] rs2_data_o;
   logic        commit_valid_o;
   logic [31:0] commit_pc_o;
   logic [31:0] retire_cnt_o;
   logic        halt_o;
   logic [31:0] a0_o;

   ysyx_24090018_wbu dut (
      .clk            (clk),
      .rst            (rst),
      .exu_valid_i    (exu_valid_i),
      .exu_ready_o    (exu_ready_o),
      .pc_i           (pc_i),
      .rf_wdata_i     (rf_wdata_i),
      .rd_i           (rd_i),
      .rf_wen_i       (rf_wen_i),
      .ebreak_i       (ebreak_i),
      .rs1_i          (rs1_i),
      .rs2_i          (rs2_i),
      .rs1_data_o     (rs1_data_o),
      .rs2_data_o     (rs2_data_o),
      .commit_valid_o (commit_valid_o),
      .commit_pc_o    (commit_pc_o),
      .retire_cnt_o   (retire_cnt_o),
      .halt_o         (halt_o),
      .a0_o           (a0_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   logic chk_en = 1'b0;
   logic cnt_load = 1'b0;

   // Model state: architectural registers and retire bookkeeping
   logic [31:0] m_regs [32];
   logic [31:0] m_cnt;
   logic [31:0] m_cpc;
   logic        m_cv;
   logic        m_halted;
   logic        m_acc;
   logic [31:0] cnt_base;

   assign m_acc    = exu_valid_i & ~m_halted & ~rst;
   assign cnt_base = cnt_load ? 32'hFFFF_FFFF : m_cnt;

   always @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 32; i++) m_regs[i] <= 32'h0;
         m_cnt    <= 32'h0;
         m_cpc    <= 32'h0;
         m_cv     <= 1'b0;
         m_halted <= 1'b0;
      end else begin
         m_cv  <= m_acc;
         m_cnt <= m_acc ? cnt_base + 32'd1 : cnt_base;
         if (m_acc) begin
            m_cpc <= pc_i;
            if (ebreak_i) m_halted <= 1'b1;
            else if (rf_wen_i && rd_i != 5'd0) m_regs[rd_i] <= rf_wdata_i;
         end
      end
   end

   function automatic logic [31:0] exp_read(input logic [4:0] idx);
      if (idx == 5'd0) return 32'h0;
      if (m_acc && !ebreak_i && rf_wen_i && rd_i == idx) return rf_wdata_i;
      return m_regs[idx];
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   // Per-cycle comparison against the model, away from the active edge
   always @(negedge clk) begin
      if (chk_en) begin
         check("ready",        32'(exu_ready_o),    32'(!m_halted));
         check("halt",         32'(halt_o),         32'(m_halted));
         check("commit_valid", 32'(commit_valid_o), 32'(m_cv));
         check("commit_pc",    commit_pc_o,         m_cpc);
         check("retire_cnt",   retire_cnt_o,        cnt_base);
         check("a0",           a0_o,                m_regs[10]);
         check("rs1_data",     rs1_data_o,          exp_read(rs1_i));
         check("rs2_data",     rs2_data_o,          exp_read(rs2_i));
      end
   end

   task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] wd,
                        input logic [4:0] rd, input logic wen, input logic eb,
                        input logic [4:0] r1, input logic [4:0] r2);
      exu_valid_i = v;
      pc_i        = pc;
      rf_wdata_i  = wd;
      rd_i        = rd;
      rf_wen_i    = wen;
      ebreak_i    = eb;
      rs1_i       = r1;
      rs2_i       = r2;
   endtask

   task automatic idle(input logic [4:0] r1, input logic [4:0] r2);
      drive(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, r1, r2);
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1);
   end

   initial begin
      rst = 1'b1;
      idle(5'd0, 5'd0);
      tick;
      chk_en = 1'b1;
      tick;
      rst = 1'b0;
      #1;
      check("post_reset_ready", 32'(exu_ready_o), 32'd1);
      check("post_reset_cnt",   retire_cnt_o,     32'd0);
      check("post_reset_halt",  32'(halt_o),      32'd0);

      // Write x5, read it back next cycle
      drive(1'b1, 32'h8000_0000, 32'h1234_5678, 5'd5, 1'b1, 1'b0, 5'd0, 5'd0);
      tick;
      idle(5'd5, 5'd0);
      #1;
      check("x5_read",     rs1_data_o,             32'h1234_5678);
      check("x5_commit",   32'(commit_valid_o),    32'd1);
      check("x5_cpc",      commit_pc_o,            32'h8000_0000);
      check("x5_cnt",      retire_cnt_o,           32'd1);
      tick;
      check("pulse_drop",  32'(commit_valid_o),    32'd0);
      check("cpc_hold",    commit_pc_o,            32'h8000_0000);

      // Write to x0 is dropped but still retires
      drive(1'b1, 32'h8000_0004, 32'hFFFF_FFFF, 5'd0, 1'b1, 1'b0, 5'd0, 5'd0);
      tick;
      idle(5'd0, 5'd0);
      #1;
      check("x0_read", rs1_data_o,   32'h0);
      check("x0_cnt",  retire_cnt_o, 32'd2);

      // Same-cycle bypass on rs2
      drive(1'b1, 32'h8000_0008, 32'h0000_00A5, 5'd7, 1'b1, 1'b0, 5'd0, 5'd7);
      #1;
      check("bypass_rs2", rs2_data_o, 32'h0000_00A5);
      tick;

      // Back-to-back writes: x3, x10, x1, x2 (reads overlap the stream)
      drive(1'b1, 32'h8000_000C, 32'h0000_0033, 5'd3, 1'b1, 1'b0, 5'd7, 5'd5);
      tick;
      drive(1'b1, 32'h8000_0010, 32'h0000_002A, 5'd10, 1'b1, 1'b0, 5'd3, 5'd10);
      tick;
      drive(1'b1, 32'h8000_0014, 32'h0000_0011, 5'd1, 1'b1, 1'b0, 5'd10, 5'd1);
      tick;
      drive(1'b1, 32'h8000_0018, 32'h0000_0022, 5'd2, 1'b0, 1'b0, 5'd1, 5'd2);
      tick;
      idle(5'd2, 5'd1);
      #1;
      check("wen0_no_write", rs1_data_o, 32'h0);
      check("x1_read",       rs2_data_o, 32'h0000_0011);
      check("a0_value",      a0_o,       32'h0000_002A);

      // ebreak with wen=1, rd=3 halts without writing x3
      drive(1'b1, 32'h8000_0020, 32'hDEAD_BEEF, 5'd3, 1'b1, 1'b1, 5'd3, 5'd0);
      #1;
      check("ebreak_no_bypass", rs1_data_o, 32'h0000_0033);
      tick;
      idle(5'd3, 5'd10);
      #1;
      check("halt_set",   32'(halt_o),      32'd1);
      check("halt_ready", 32'(exu_ready_o), 32'd0);
      check("halt_x3",    rs1_data_o,       32'h0000_0033);
      check("halt_a0",    a0_o,             32'h0000_002A);
      check("halt_cnt",   retire_cnt_o,     32'd8);
      check("halt_cpc",   commit_pc_o,      32'h8000_0020);
      drive(1'b1, 32'h8000_0024, 32'h0000_BEEF, 5'd3, 1'b1, 1'b0, 5'd3, 5'd0);
      tick;
      tick;
      check("halt_ignore_x3",  rs1_data_o,             32'h0000_0033);
      check("halt_ignore_cnt", retire_cnt_o,           32'd8);
      check("halt_ignore_cv",  32'(commit_valid_o),    32'd0);

      // Reset leaves HALT; accept allowed in the first cycle after
      rst = 1'b1;
      tick;
      rst = 1'b0;
      drive(1'b1, 32'h8000_0030, 32'h0000_0055, 5'd4, 1'b1, 1'b0, 5'd3, 5'd10);
      #1;
      check("rst_exit_halt",  32'(halt_o),      32'd0);
      check("rst_exit_ready", 32'(exu_ready_o), 32'd1);
      check("rst_x3_clear",   rs1_data_o,       32'h0);
      check("rst_a0_clear",   a0_o,             32'h0);
      tick;
      idle(5'd4, 5'd0);
      #1;
      check("first_acc_x4",  rs1_data_o,   32'h0000_0055);
      check("first_acc_cnt", retire_cnt_o, 32'd1);

      // Counter wrap from a forced all-ones value
      drive(1'b1, 32'h8000_0040, 32'h0000_0006, 5'd6, 1'b1, 1'b0, 5'd6, 5'd4);
      force dut.retire_cnt_q = 32'hFFFF_FFFF;
      cnt_load = 1'b1;
      #1;
      release dut.retire_cnt_q;
      tick;
      cnt_load = 1'b0;
      #1;
      check("cnt_wrap", retire_cnt_o, 32'd0);

      // Reset asserted during an accept of x4 discards it
      drive(1'b1, 32'h8000_0050, 32'h0000_0099, 5'd4, 1'b1, 1'b0, 5'd4, 5'd6);
      rst = 1'b1;
      tick;
      rst = 1'b0;
      idle(5'd4, 5'd6);
      #1;
      check("rst_acc_x4",    rs1_data_o,          32'h0);
      check("rst_acc_halt",  32'(halt_o),         32'd0);
      check("rst_acc_cv",    32'(commit_valid_o), 32'd0);
      check("rst_acc_ready", 32'(exu_ready_o),    32'd1);
      check("rst_acc_cnt",   retire_cnt_o,        32'd0);
      tick;
      tick;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
